instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 134 +++++++++++++
 tb/tb_instr_encoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs register/immediate fields into a 32-bit instruction
// for a one-hot opcode class and queues the result in a small output FIFO.
// Invalid codes still complete the handshake but are dropped, flagged on err
// for one cycle and counted in a saturating error counter.
module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] code,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rs3,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [7:0]  err_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    // Opcode-class bits grouped by instruction format
    localparam logic [31:0] FMT_I  = 32'h1200_005B; // 0,1,3,4,6,25,28
    localparam logic [31:0] FMT_U  = 32'h0000_2020; // 5,13
    localparam logic [31:0] FMT_S  = 32'h0000_0300; // 8,9
    localparam logic [31:0] FMT_R  = 32'h0010_5800; // 11,12,14,20
    localparam logic [31:0] FMT_R4 = 32'h000F_0000; // 16-19
    localparam logic [31:0] FMT_B  = 32'h0100_0000; // 24
    localparam logic [31:0] FMT_J  = 32'h0800_0000; // 27
    localparam logic [31:0] FMT_ANY = FMT_I | FMT_U | FMT_S | FMT_R | FMT_R4 | FMT_B | FMT_J;

    logic [DEPTH-1:0][31:0] mem_q, mem_d;
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   err_q, err_d;
    logic [7:0]             err_count_q, err_count_d;
    logic                   live_q, live_d;   // low until the first edge after reset

    logic [4:0]  idx;
    logic        one_hot, code_ok;
    logic [6:0]  op;
    logic [31:0] enc;
    logic        accept, push, pop;

    // Opcode index and validity of the requested class
    always_comb begin
        idx = '0;
        for (int i = 0; i < 32; i++)
            if (code[i]) idx = 5'(i);
        one_hot = (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0);
        code_ok = one_hot && ((code & FMT_ANY) != 32'd0);
        op      = {idx, 2'b11};
    end

    // Field packing for the selected format
    always_comb begin
        enc = 32'd0;
        if ((code & FMT_R) != 0)
            enc = {funct7, rs2, rs1, funct3, rd, op};
        else if ((code & FMT_R4) != 0)
            enc = {rs3, funct7[1:0], rs2, rs1, funct3, rd, op};
        else if ((code & FMT_I) != 0)
            enc = {imm[11:0], rs1, funct3, rd, op};
        else if ((code & FMT_S) != 0)
            enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        else if ((code & FMT_B) != 0)
            enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        else if ((code & FMT_U) != 0)
            enc = {imm[31:12], rd, op};
        else if ((code & FMT_J) != 0)
            enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    end

    assign in_ready  = live_q && (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign instr     = out_valid ? mem_q[rptr_q] : 32'd0;
    assign err       = err_q;
    assign err_count = err_count_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && code_ok;
    assign pop    = out_valid && out_ready;

    // FIFO pointers/count and error bookkeeping
    always_comb begin
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        live_d      = 1'b1;
        err_d       = accept && !code_ok;
        err_count_d = err_count_q;
        if (push) begin
            mem_d[wptr_d] = enc;
            wptr_d        = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop)
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        if (err_d && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            live_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            mem_q       <= mem_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            live_q      <= live_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed expected encodings.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] code, imm;
    logic [4:0]  rd, rs1, rs2, rs3;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [31:0] instr;
    logic [7:0]  err_count;

    int n_vec = 0;
    int n_err = 0;

    instr_encoder #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .code(code), .rd(rd), .rs1(rs1), .rs2(rs2),
        .rs3(rs3), .funct3(funct3), .funct7(funct7), .imm(imm),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .err(err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] c, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
        code = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
        rs3 = 5'd0; funct7 = 7'd0;
    endtask

    // Push one request into an empty FIFO, check it, then pop it
    task automatic push_check(input string tag, input logic [31:0] exp);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk(tag, instr, exp);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    localparam logic [31:0] VALID_CODES = 32'h1B1F_7B7B;
    logic [31:0] vmask;
    logic [31:0] bad_codes [4];

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_req(32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        #12;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("rdy_before_edge", 32'(in_ready), 32'd0);
        tick;
        chk("rdy_after_edge", 32'(in_ready), 32'd1);

        // Opcode sweep over every valid class
        vmask = VALID_CODES;
        for (int i = 0; i < 32; i++) begin
            if (vmask[i]) begin
                set_req(32'd1 << i, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0);
                in_valid = 1'b1;
                tick;
                in_valid = 1'b0;
                chk($sformatf("op%0d", i), 32'(instr[6:0]), 32'({i[4:0], 2'b11}));
                if (i == 12) chk("add_full", instr, 32'h003100B3);
                out_ready = 1'b1;
                tick;
                out_ready = 1'b0;
            end
        end

        set_req(32'h0000_0010, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
        push_check("addi", 32'hFFF00293);
        set_req(32'h0000_2000, 5'd1, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        push_check("lui", 32'h123450B7);
        set_req(32'h0100_0000, 5'd0, 5'd1, 5'd2, 3'd1, 32'hFFFF_FFFC);
        push_check("bne", 32'hFE209EE3);
        set_req(32'h0800_0000, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8);
        push_check("jal", 32'h008000EF);

        // Invalid codes: dropped, one-cycle err, counted
        bad_codes[0] = 32'h3; bad_codes[1] = 32'h0;
        bad_codes[2] = 32'h8000_0000; bad_codes[3] = 32'h4;
        for (int k = 0; k < 4; k++) begin
            set_req(bad_codes[k], 5'd1, 5'd2, 5'd3, 3'd0, 32'd0);
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            chk($sformatf("bad%0d_err", k), 32'(err), 32'd1);
            chk($sformatf("bad%0d_vld", k), 32'(out_valid), 32'd0);
            tick;
            chk($sformatf("bad%0d_errlow", k), 32'(err), 32'd0);
        end
        chk("err_count4", 32'(err_count), 32'd4);

        // Backpressure with DEPTH+1 pushes, then drain with push+pop overlap
        out_ready = 1'b0;
        set_req(32'h10, 5'd5, 5'd0, 5'd0, 3'd0, 32'd1);
        in_valid = 1'b1;
        tick;
        chk("f1_rdy", 32'(in_ready), 32'd1);
        chk("f1_head", instr, 32'h00100293);
        imm = 32'd2;
        tick;
        chk("f2_rdy", 32'(in_ready), 32'd0);
        chk("f2_head", instr, 32'h00100293);
        imm = 32'd3;
        tick;
        chk("f3_rdy", 32'(in_ready), 32'd0);
        chk("f3_hold", instr, 32'h00100293);
        out_ready = 1'b1;
        tick;
        chk("d1_head", instr, 32'h00200293);
        chk("d1_rdy", 32'(in_ready), 32'd1);
        tick;
        chk("pp_head", instr, 32'h00300293);
        chk("pp_vld", 32'(out_valid), 32'd1);
        chk("pp_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick;
        chk("d3_vld", 32'(out_valid), 32'd0);
        chk("d3_instr", instr, 32'd0);
        out_ready = 1'b0;

        // Mid-stream reset with two entries buffered
        in_valid = 1'b1;
        imm = 32'd7;
        tick;
        tick;
        in_valid = 1'b0;
        chk("pre_rst_vld", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_instr", instr, 32'd0);
        chk("mrst_errcnt", 32'(err_count), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd0);
        #1 reset = 1'b0;
        tick;
        chk("post_rst_rdy", 32'(in_ready), 32'd1);
        chk("post_rst_vld", 32'(out_valid), 32'd0);
        chk("post_rst_instr", instr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
